time_keeper: RTL and testbench

BCD time-of-day core for the clock/calendar design. Divides the system clock to a 1 Hz tick and counts seconds, minutes and hours (00:00:00–23:59:59) in packed BCD. Hour/minute adjustment is done with synchronized key presses in a separate adjust mode. It drives Hour/Minute/Second into the alarm stage and issues a day-carry pulse to the calendar stage.

---
 rtl/time_keeper.sv | 147 ++++++++++++++
 tb/tb_time_keeper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// BCD time-of-day core: 1 Hz prescaler, HH:MM:SS counting, and a key-driven
// adjust mode for hours and minutes. Feeds the alarm and calendar stages.
module time_keeper #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic       AdjMode,
    input  logic       AdjHrKey,
    input  logic       AdjMinKey,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       Sec_Tick,
    output logic       Day_Carry
);

    typedef enum logic {RUN, ADJ} state_t;

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    // Returns {carry, next} for a 00..59 BCD field.
    function automatic logic [8:0] inc_bcd59(input logic [7:0] v);
        if (v[3:0] != 4'd9)      return {1'b0, v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
        else                     return {1'b1, 8'h00};
    endfunction

    // Returns {carry, next} for a 00..23 BCD hour.
    function automatic logic [8:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23)          return {1'b1, 8'h00};
        else if (v[3:0] != 4'd9) return {1'b0, v[7:4], v[3:0] + 4'd1};
        else                     return {1'b0, v[7:4] + 4'd1, 4'd0};
    endfunction

    logic mode_s1_q, mode_s2_q;
    logic hr_s1_q, hr_s2_q, hr_prev_q;
    logic min_s1_q, min_s2_q, min_prev_q;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            hr_s1_q    <= 1'b0;
            hr_s2_q    <= 1'b0;
            hr_prev_q  <= 1'b0;
            min_s1_q   <= 1'b0;
            min_s2_q   <= 1'b0;
            min_prev_q <= 1'b0;
        end else begin
            mode_s1_q  <= AdjMode;
            mode_s2_q  <= mode_s1_q;
            hr_s1_q    <= AdjHrKey;
            hr_s2_q    <= hr_s1_q;
            hr_prev_q  <= hr_s2_q;
            min_s1_q   <= AdjMinKey;
            min_s2_q   <= min_s1_q;
            min_prev_q <= min_s2_q;
        end
    end

    logic hr_pulse, min_pulse;
    assign hr_pulse  = hr_s2_q & ~hr_prev_q;
    assign min_pulse = min_s2_q & ~min_prev_q;

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [7:0]  hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic        tick_q, tick_d, carry_q, carry_d;
    logic [8:0]  sec_inc, min_inc, hour_inc;

    assign sec_inc  = inc_bcd59(sec_q);
    assign min_inc  = inc_bcd59(min_q);
    assign hour_inc = inc_hour(hour_q);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        case (state_q)
            RUN: begin
                // Mode change wins over a tick due on the same edge.
                if (mode_s2_q) begin
                    state_d = ADJ;
                    pre_d   = '0;
                    sec_d   = 8'h00;
                end else if (EN) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        sec_d  = sec_inc[7:0];
                        if (sec_inc[8]) min_d = min_inc[7:0];
                        if (sec_inc[8] && min_inc[8]) begin
                            hour_d  = hour_inc[7:0];
                            carry_d = hour_inc[8];
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
            end
            ADJ: begin
                pre_d = '0;
                sec_d = 8'h00;
                if (!mode_s2_q) begin
                    state_d = RUN;
                end else begin
                    if (min_pulse) min_d  = min_inc[7:0];
                    if (hr_pulse)  hour_d = hour_inc[7:0];
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q <= RUN;
            pre_q   <= '0;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign Hour      = hour_q;
    assign Minute    = min_q;
    assign Second    = sec_q;
    assign Sec_Tick  = tick_q;
    assign Day_Carry = carry_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV = 4: vector table for the
// first seconds after reset, then hand sequences for adjust, rollover and races.
module tb_time_keeper;

    localparam int unsigned DIV = 4;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       EN = 1'b0;
    logic       AdjMode = 1'b0;
    logic       AdjHrKey = 1'b0;
    logic       AdjMinKey = 1'b0;
    logic [7:0] Hour, Minute, Second;
    logic       Sec_Tick, Day_Carry;

    int checks = 0;
    int passed = 0;
    int tick_count = 0;
    int carry_count = 0;

    time_keeper #(.TICK_DIV(DIV)) dut (
        .CP(CP), .nCR(nCR), .EN(EN), .AdjMode(AdjMode),
        .AdjHrKey(AdjHrKey), .AdjMinKey(AdjMinKey),
        .Hour(Hour), .Minute(Minute), .Second(Second),
        .Sec_Tick(Sec_Tick), .Day_Carry(Day_Carry)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic       en;
        logic       hr;
        logic       mn;
        logic [7:0] sec;
        logic       tick;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge CP);
        @(negedge CP);
        if (Sec_Tick)  tick_count++;
        if (Day_Carry) carry_count++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
        chk(name, {8'h00, Hour, Minute, Second}, {8'h00, h, m, s});
    endtask

    task automatic press(input logic hr, input logic mn);
        AdjHrKey  = hr;
        AdjMinKey = mn;
        repeat (3) step();
        AdjHrKey  = 1'b0;
        AdjMinKey = 1'b0;
        repeat (3) step();
    endtask

    task automatic set_mode(input logic m);
        AdjMode = m;
        repeat (3) step();
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!Sec_Tick && cyc < 64);
        if (!Sec_Tick) begin
            checks++;
            $display("FAIL tick_timeout: no Sec_Tick within %0d cycles", cyc);
        end
    endtask

    task automatic run_ticks(input int n);
        int c;
        repeat (n) wait_tick(c);
    endtask

    initial begin
        int c;
        int cbase;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b0};

        EN = 1'b1;
        repeat (2) step();
        chk_time("reset_time", 8'h00, 8'h00, 8'h00);
        chk("reset_tick", 32'(Sec_Tick), 32'd0);
        chk("reset_carry", 32'(Day_Carry), 32'd0);

        nCR = 1'b1;
        for (int i = 0; i < 16; i++) begin
            EN        = vecs[i].en;
            AdjHrKey  = vecs[i].hr;
            AdjMinKey = vecs[i].mn;
            step();
            chk($sformatf("vec%0d_sec", i), 32'(Second), 32'(vecs[i].sec));
            chk($sformatf("vec%0d_tick", i), 32'(Sec_Tick), 32'(vecs[i].tick));
            chk($sformatf("vec%0d_hm", i), {16'h0, Hour, Minute}, 32'h0);
        end
        AdjHrKey  = 1'b0;
        AdjMinKey = 1'b0;

        // EN gating: 10 idle cycles stretch the next interval to DIV+10
        wait_tick(c);
        chk("tick_resume_gap", 32'(c), 32'd3);
        cbase = tick_count;
        EN = 1'b0;
        repeat (10) step();
        chk("en_low_no_tick", 32'(tick_count - cbase), 32'd0);
        EN = 1'b1;
        wait_tick(c);
        chk("en_stretch_gap", 32'(c), 32'(DIV));
        chk("en_stretch_sec", 32'(Second), 32'h05);

        // Preset 12:34 by adjust, then run 56 seconds
        set_mode(1'b1);
        chk("adj_entry_sec", 32'(Second), 32'h00);
        repeat (12) press(1'b1, 1'b0);
        repeat (34) press(1'b0, 1'b1);
        chk_time("preset_1234", 8'h12, 8'h34, 8'h00);
        set_mode(1'b0);
        run_ticks(56);
        chk_time("run_123456", 8'h12, 8'h34, 8'h56);

        AdjMode = 1'b1;
        step();
        chk("mode_edge1_sec", 32'(Second), 32'h56);
        step();
        chk("mode_edge2_sec", 32'(Second), 32'h56);
        step();
        chk("mode_edge3_sec", 32'(Second), 32'h00);
        chk("mode_edge3_tick", 32'(Sec_Tick), 32'd0);

        cbase = carry_count;
        for (int i = 1; i <= 26; i++) begin
            press(1'b0, 1'b1);
            if (i == 25) chk("adj_min_59", 32'(Minute), 32'h59);
        end
        chk_time("adj_min_wrap", 8'h12, 8'h00, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            press(1'b1, 1'b0);
            if (i == 11) chk("adj_hr_23", 32'(Hour), 32'h23);
        end
        chk("adj_hr_wrap", 32'(Hour), 32'h00);
        chk("adj_no_carry", 32'(carry_count - cbase), 32'd0);

        AdjHrKey  = 1'b1;
        AdjMinKey = 1'b1;
        step();
        step();
        chk("both_before", {16'h0, Hour, Minute}, 32'h0000);
        step();
        chk("both_after", {16'h0, Hour, Minute}, 32'h0101);
        AdjHrKey  = 1'b0;
        AdjMinKey = 1'b0;
        repeat (3) step();

        // Day rollover from 23:59:59
        repeat (22) press(1'b1, 1'b0);
        repeat (58) press(1'b0, 1'b1);
        chk_time("preset_2359", 8'h23, 8'h59, 8'h00);
        set_mode(1'b0);
        cbase = carry_count;
        run_ticks(59);
        chk_time("run_235959", 8'h23, 8'h59, 8'h59);
        chk("no_early_carry", 32'(carry_count - cbase), 32'd0);
        wait_tick(c);
        chk_time("rollover_time", 8'h00, 8'h00, 8'h00);
        chk("rollover_tick", 32'(Sec_Tick), 32'd1);
        chk("rollover_carry", 32'(Day_Carry), 32'd1);
        step();
        chk("rollover_tick_off", 32'(Sec_Tick), 32'd0);
        chk("rollover_carry_off", 32'(Day_Carry), 32'd0);
        chk("rollover_carry_once", 32'(carry_count - cbase), 32'd1);

        run_ticks(9);
        chk("sec_09", 32'(Second), 32'h09);
        run_ticks(1);
        chk("sec_10", 32'(Second), 32'h10);

        set_mode(1'b1);
        repeat (59) press(1'b0, 1'b1);
        set_mode(1'b0);
        run_ticks(59);
        chk_time("run_005959", 8'h00, 8'h59, 8'h59);
        cbase = carry_count;
        run_ticks(1);
        chk_time("wrap_010000", 8'h01, 8'h00, 8'h00);
        chk("wrap_01_no_carry", 32'(carry_count - cbase), 32'd0);

        set_mode(1'b1);
        repeat (8) press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        chk_time("preset_0959", 8'h09, 8'h59, 8'h00);
        set_mode(1'b0);
        run_ticks(60);
        chk_time("wrap_100000", 8'h10, 8'h00, 8'h00);

        // Tick due on the RUN->ADJ edge is dropped
        run_ticks(1);
        step();
        AdjMode = 1'b1;
        step();
        step();
        chk("race_before_sec", 32'(Second), 32'h01);
        step();
        chk("race_sec_cleared", 32'(Second), 32'h00);
        chk("race_tick_dropped", 32'(Sec_Tick), 32'd0);

        repeat (19) press(1'b1, 1'b0);
        repeat (43) press(1'b0, 1'b1);
        chk_time("preset_0543", 8'h05, 8'h43, 8'h00);

        // Key pulse on the ADJ->RUN edge is ignored
        AdjMode   = 1'b0;
        AdjMinKey = 1'b1;
        repeat (3) step();
        chk("exit_race_min", 32'(Minute), 32'h43);
        step();
        AdjMinKey = 1'b0;
        step();
        chk("exit_race_min_held", 32'(Minute), 32'h43);
        run_ticks(21);
        chk_time("run_054321", 8'h05, 8'h43, 8'h21);

        #2 nCR = 1'b0;
        #1;
        chk_time("async_reset_time", 8'h00, 8'h00, 8'h00);
        chk("async_reset_tick", 32'(Sec_Tick), 32'd0);
        chk("async_reset_carry", 32'(Day_Carry), 32'd0);
        @(negedge CP);
        nCR = 1'b1;
        wait_tick(c);
        chk("restart_first_tick", 32'(c), 32'(DIV));
        chk_time("restart_time", 8'h00, 8'h00, 8'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
